// File: rtl/vga_vram_arbiter.sv
// Shares one single-port synchronous video RAM between VGA scanout and CPU accesses.
// The VGA side owns the scanout address and pixel shift register; the CPU side is a 4-state FSM.
module vga_vram_arbiter #(
  parameter int H_ACTIVE = 640,
  parameter int V_ACTIVE = 480,
  parameter int ADDR_W   = 17
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [9:0]        i_HPos,
  input  logic [9:0]        i_VPos,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [15:0]       cpu_wdata,
  output logic              cpu_ready,
  output logic [15:0]       cpu_rdata,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [15:0]       mem_wdata,
  input  logic [15:0]       mem_rdata,
  output logic [3:0]        pix_data,
  output logic              pix_valid
);

  localparam logic [9:0] H_LIM = 10'(H_ACTIVE);
  localparam logic [9:0] V_LIM = 10'(V_ACTIVE);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ISSUE   = 2'd1,
    CAPTURE = 2'd2,
    DONE    = 2'd3
  } cpu_state_t;

  cpu_state_t        state_r;
  cpu_state_t        state_next_s;
  logic              active_s;
  logic              slot_s;
  logic              grant_s;
  logic              wrap_s;
  logic [ADDR_W-1:0] vga_addr_r;
  logic              cpu_we_r;
  logic              act_d1_r;
  logic              act_d2_r;
  logic              slot_d1_r;
  logic              slot_d2_r;
  logic [15:0]       shift_r;

  // VGA slot wins over the CPU; the CPU is only granted from IDLE outside a slot
  always_comb begin
    active_s = (i_HPos < H_LIM) && (i_VPos < V_LIM);
    slot_s   = active_s && (i_HPos[1:0] == 2'b00);
    grant_s  = (state_r == IDLE) && cpu_req && !slot_s;
    wrap_s   = (i_VPos == V_LIM);
  end

  always_comb begin
    state_next_s = state_r;
    case (state_r)
      IDLE: begin
        if (grant_s) state_next_s = ISSUE;
        else         state_next_s = IDLE;
      end
      ISSUE:   state_next_s = CAPTURE;
      CAPTURE: state_next_s = DONE;
      DONE:    state_next_s = IDLE;
      default: state_next_s = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_r <= IDLE;
    else     state_r <= state_next_s;
  end

  // Single bus owner per cycle; address and write data hold while the bus is idle
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem_en    <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= {ADDR_W{1'b0}};
      mem_wdata <= 16'h0000;
    end else if (slot_s) begin
      mem_en    <= 1'b1;
      mem_we    <= 1'b0;
      mem_addr  <= vga_addr_r;
    end else if (grant_s) begin
      mem_en    <= 1'b1;
      mem_we    <= cpu_we;
      mem_addr  <= cpu_addr;
      mem_wdata <= cpu_wdata;
    end else begin
      mem_en    <= 1'b0;
      mem_we    <= 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)         vga_addr_r <= {ADDR_W{1'b0}};
    else if (wrap_s) vga_addr_r <= {ADDR_W{1'b0}};
    else if (slot_s) vga_addr_r <= vga_addr_r + ADDR_W'(1);
    else             vga_addr_r <= vga_addr_r;
  end

  // RAM data in CAPTURE always belongs to the CPU access, since VGA reads land one cycle after a slot
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cpu_we_r  <= 1'b0;
      cpu_ready <= 1'b0;
      cpu_rdata <= 16'h0000;
    end else begin
      if (grant_s) cpu_we_r <= cpu_we;
      else         cpu_we_r <= cpu_we_r;
      cpu_ready <= (state_r == CAPTURE);
      if ((state_r == CAPTURE) && !cpu_we_r) cpu_rdata <= mem_rdata;
      else                                   cpu_rdata <= cpu_rdata;
    end
  end

  // Word arrives two clocks after the slot; pixels leave lowest nibble first, 3 clocks behind HPos
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      act_d1_r  <= 1'b0;
      act_d2_r  <= 1'b0;
      pix_valid <= 1'b0;
      slot_d1_r <= 1'b0;
      slot_d2_r <= 1'b0;
      shift_r   <= 16'h0000;
      pix_data  <= 4'h0;
    end else begin
      act_d1_r  <= active_s;
      act_d2_r  <= act_d1_r;
      pix_valid <= act_d2_r;
      slot_d1_r <= slot_s;
      slot_d2_r <= slot_d1_r;
      if (slot_d2_r) begin
        shift_r  <= mem_rdata;
        pix_data <= act_d2_r ? mem_rdata[3:0] : 4'h0;
      end else begin
        shift_r  <= {4'h0, shift_r[15:4]};
        pix_data <= act_d2_r ? shift_r[7:4] : 4'h0;
      end
    end
  end

endmodule

// File: tb/tb_vga_vram_arbiter.sv
// Directed bench for vga_vram_arbiter with a reduced frame, a RAM model and a due-cycle scoreboard.
module tb_vga_vram_arbiter;

  localparam int HA = 32;
  localparam int VA = 6;
  localparam int HT = 48;
  localparam int VT = 8;
  localparam int AW = 17;

  logic          clk = 1'b0;
  logic          rst;
  logic [9:0]    hpos;
  logic [9:0]    vpos;
  logic          cpu_req;
  logic          cpu_we;
  logic [AW-1:0] cpu_addr;
  logic [15:0]   cpu_wdata;
  logic          cpu_ready;
  logic [15:0]   cpu_rdata;
  logic          mem_en;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [15:0]   mem_wdata;
  logic [15:0]   mem_rdata;
  logic [3:0]    pix_data;
  logic          pix_valid;

  always #5 clk = ~clk;

  vga_vram_arbiter #(.H_ACTIVE(HA), .V_ACTIVE(VA), .ADDR_W(AW)) dut (
    .clk(clk), .rst(rst), .i_HPos(hpos), .i_VPos(vpos),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_ready(cpu_ready), .cpu_rdata(cpu_rdata),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .pix_data(pix_data), .pix_valid(pix_valid)
  );

  function automatic logic [15:0] pattern(input int a);
    logic [15:0] x;
    x = 16'(a);
    return 16'h4321 + x * 16'h0101;
  endfunction

  // RAM model: unwritten words read back as pattern(address)
  bit [15:0] ram_w [0:1023];
  bit        ram_v [0:1023];
  always @(posedge clk) begin
    if (mem_en) begin
      if (mem_we) begin
        ram_w[mem_addr[9:0]] <= mem_wdata;
        ram_v[mem_addr[9:0]] <= 1'b1;
      end else begin
        mem_rdata <= ram_v[mem_addr[9:0]] ? ram_w[mem_addr[9:0]] : pattern(int'(mem_addr));
      end
    end
  end

  typedef struct {
    int          due;
    int          kind;   // 0 pixel, 1 bus read, 2 bus write, 3 cpu ready
    logic [16:0] addr;
    logic [15:0] data;
    logic        we;
  } sb_t;

  sb_t         sb[$];
  int          n_vec = 0;
  int          n_err = 0;
  int          cyc = 0;
  int          m_free = 0;
  int          m_ready = -1;
  bit          prev_rst = 1'b0;
  logic [15:0] exp_rdata;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    assert (got === exp) else begin
      n_err++;
      $error("FAIL %s got=%h exp=%h cyc=%0d h=%0d v=%0d", tag, got, exp, cyc, hpos, vpos);
    end
  endtask

  // Push what the DUT must show for the inputs of the current cycle
  task automatic eval();
    bit          act;
    bit          slot;
    int          word;
    logic [15:0] wv;
    logic [3:0]  nib;
    if (rst) begin
      if (!prev_rst) sb.delete();
      prev_rst = 1'b1;
      m_free   = 0;
      sb.push_back('{cyc + 3, 0, 17'd0, 16'd0, 1'b0});
      return;
    end
    prev_rst = 1'b0;
    act  = (int'(hpos) < HA) && (int'(vpos) < VA);
    slot = act && (hpos[1:0] == 2'b00);
    word = int'(vpos) * (HA / 4) + int'(hpos) / 4;
    wv   = pattern(word);
    nib  = act ? wv[4 * int'(hpos[1:0]) +: 4] : 4'h0;
    sb.push_back('{cyc + 3, 0, 17'd0, {12'h000, nib}, act});
    if (slot) begin
      sb.push_back('{cyc + 1, 1, 17'(word), 16'd0, 1'b0});
    end else if ((cyc >= m_free) && cpu_req) begin
      sb.push_back('{cyc + 1, cpu_we ? 2 : 1, cpu_addr, cpu_wdata, cpu_we});
      sb.push_back('{cyc + 3, 3, 17'd0, exp_rdata, cpu_we});
      m_free  = cyc + 4;
      m_ready = cyc + 3;
    end
  endtask

  task automatic check();
    bit bus_due = 1'b0;
    bit rdy_due = 1'b0;
    for (int i = sb.size() - 1; i >= 0; i--) begin
      if (sb[i].due == cyc) begin
        case (sb[i].kind)
          0: chk("pixel", 32'({pix_valid, pix_data}), 32'({sb[i].we, sb[i].data[3:0]}));
          1: begin
            bus_due = 1'b1;
            chk("bus_rd", 32'({mem_en, mem_we, mem_addr}), 32'({1'b1, 1'b0, sb[i].addr}));
          end
          2: begin
            bus_due = 1'b1;
            chk("bus_wr", 32'({mem_en, mem_we, mem_addr}), 32'({1'b1, 1'b1, sb[i].addr}));
            chk("bus_wdata", 32'(mem_wdata), 32'(sb[i].data));
          end
          default: begin
            rdy_due = 1'b1;
            chk("cpu_ready", 32'(cpu_ready), 32'd1);
            if (!sb[i].we) chk("cpu_rdata", 32'(cpu_rdata), 32'(sb[i].data));
          end
        endcase
        sb.delete(i);
      end
    end
    if (!bus_due) chk("bus_idle", 32'(mem_en), 32'd0);
    if (!rdy_due) chk("no_ready", 32'(cpu_ready), 32'd0);
  endtask

  task automatic tick();
    eval();
    @(negedge clk);
    check();
    @(posedge clk);
    #1;
    cyc++;
    if (int'(hpos) == HT - 1) begin
      hpos = 10'd0;
      vpos = (int'(vpos) == VT - 1) ? 10'd0 : vpos + 10'd1;
    end else begin
      hpos = hpos + 10'd1;
    end
  endtask

  task automatic goto_pos(input int th, input int tv);
    int n = 0;
    while (!(int'(hpos) == th && int'(vpos) == tv) && n < 2000) begin
      tick();
      n++;
    end
    if (n >= 2000) begin
      n_vec++;
      n_err++;
      $error("FAIL goto_timeout h=%0d v=%0d", th, tv);
    end
  endtask

  task automatic cpu_access(input logic we, input int addr, input logic [15:0] wd, input logic [15:0] rd);
    int start = cyc;
    cpu_req   = 1'b1;
    cpu_we    = we;
    cpu_addr  = AW'(addr);
    cpu_wdata = wd;
    exp_rdata = rd;
    m_ready   = -1;
    while ((m_ready < 0 || cyc < m_ready) && (cyc - start) < 16) tick();
    if (m_ready < 0 || cyc != m_ready) begin
      n_vec++;
      n_err++;
      $error("FAIL cpu_grant_timeout addr=%0d", addr);
    end
    cpu_req = 1'b0;
  endtask

  initial begin
    rst = 1'b1; hpos = 10'd20; vpos = 10'd3;
    cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = 16'h0; exp_rdata = 16'h0;
    repeat (3) tick();
    chk("rst_bus", 32'({mem_en, mem_we, mem_addr}), 32'd0);
    chk("rst_cpu", 32'({cpu_ready, cpu_rdata}), 32'd0);
    chk("rst_pix", 32'({pix_valid, pix_data}), 32'd0);

    // release at the frame origin: first fetch at HPos 1, pixels 1,2,3,4 from HPos 3
    rst = 1'b0; hpos = 10'd0; vpos = 10'd0;
    tick();
    chk("first_fetch", 32'({mem_en, mem_we, mem_addr}), 32'({1'b1, 1'b0, 17'd0}));
    tick();
    chk("valid_low_h2", 32'(pix_valid), 32'd0);
    tick();
    chk("pix_h3", 32'({pix_valid, pix_data}), 32'({1'b1, 4'd1}));
    tick();
    chk("pix_h4", 32'({pix_valid, pix_data}), 32'({1'b1, 4'd2}));
    tick();
    chk("pix_h5", 32'({pix_valid, pix_data}), 32'({1'b1, 4'd3}));
    tick();
    chk("pix_h6", 32'({pix_valid, pix_data}), 32'({1'b1, 4'd4}));

    // frame wrap: the next frame fetches word 0 again
    goto_pos(1, 0);
    chk("wrap_fetch", 32'({mem_en, mem_addr}), 32'({1'b1, 17'd0}));

    // read in a slot cycle is deferred one cycle
    goto_pos(8, 1);
    cpu_access(1'b0, 5, 16'h0000, pattern(5));
    chk("rd5_ready", 32'({cpu_ready, cpu_rdata}), 32'({1'b1, pattern(5)}));

    // write then read back in blanking
    goto_pos(40, 1);
    cpu_access(1'b1, 100, 16'hBEEF, 16'h0000);
    cpu_access(1'b0, 100, 16'h0000, 16'hBEEF);
    chk("rd100", 32'(cpu_rdata), 32'h0000BEEF);

    // back-to-back reads across a whole active line
    for (int i = 0; i < 40 && !(int'(vpos) == 3 && int'(hpos) >= 4); i++) begin
      cpu_access(1'b0, 20 + i, 16'h0000, pattern(20 + i));
    end

    // reset while the CPU access sits in CAPTURE
    goto_pos(40, 4);
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = AW'(7); exp_rdata = pattern(7);
    tick();
    tick();
    rst = 1'b1;
    cpu_req = 1'b0;
    #1;
    chk("rst7_bus", 32'({mem_en, mem_we, mem_addr}), 32'd0);
    chk("rst7_wdata", 32'(mem_wdata), 32'd0);
    chk("rst7_cpu", 32'({cpu_ready, cpu_rdata}), 32'd0);
    chk("rst7_pix", 32'({pix_valid, pix_data}), 32'd0);
    repeat (3) tick();
    rst = 1'b0; hpos = 10'd0; vpos = 10'd0;
    repeat (60) tick();
    cpu_access(1'b0, 9, 16'h0000, pattern(9));
    repeat (8) tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
